vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator that owns the column/row counters and produces porch-correct, polarity-configurable Hsync/Vsync.
- Also produces active-video and line/frame-start strobes.
- Supersedes external counter + porch-masking logic; sits between the pixel clock domain and the pixel/ball/paddle renderers.
- Mode (640x480@60 default) is fully set by parameters.

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Owns the column/row counters and produces registered, polarity-configurable
// Hsync/Vsync, an active-video flag and line/frame-start strobes. Every
// level output is decoded from the next counter values, so it always
// describes the o_Col/o_Row shown in the same cycle.
module vga_timing_gen #(
    parameter int ACTIVE_COLS   = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int ACTIVE_ROWS   = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int CNT_W         = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Enable,
    input  logic             i_Pix_En,
    output logic [CNT_W-1:0] o_Col,
    output logic [CNT_W-1:0] o_Row,
    output logic             o_Hsync,
    output logic             o_Vsync,
    output logic             o_Active,
    output logic             o_Line_Start,
    output logic             o_Frame_Start
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] COL_ACT  = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] ROW_ACT  = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

    localparam logic HS_IDLE = ~H_SYNC_POL;
    localparam logic VS_IDLE = ~V_SYNC_POL;

    // Illegal timing parameters are rejected while the design is elaborated.
    if (H_FRONT_PORCH < 1 || H_SYNC_WIDTH < 1 || H_BACK_PORCH < 1 ||
        V_FRONT_PORCH < 1 || V_SYNC_WIDTH < 1 || V_BACK_PORCH < 1) begin : g_bad_porch
        $error("vga_timing_gen: every porch and sync width must be >= 1");
    end
    if (TOTAL_COLS > (1 << CNT_W) || TOTAL_ROWS > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too small for TOTAL_COLS/TOTAL_ROWS");
    end

    logic [CNT_W-1:0] col_nxt;
    logic [CNT_W-1:0] row_nxt;
    logic             col_wrap;
    logic             row_wrap;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             active_nxt;

    // Next counter position: advance on a pixel strobe, wrapping column then row.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_nxt  = o_Col;
        row_nxt  = o_Row;
        col_wrap = 1'b0;
        row_wrap = 1'b0;
        if (i_Pix_En) begin
            if (o_Col == COL_LAST) begin
                col_nxt  = '0;
                col_wrap = 1'b1;
                if (o_Row == ROW_LAST) begin
                    row_nxt  = '0;
                    row_wrap = 1'b1;
                end else begin
                    row_nxt = o_Row + CNT_W'(1);
                end
            end else begin
                col_nxt = o_Col + CNT_W'(1);
            end
        end
    end

    // Sync and active-video decode of the position that will be shown next cycle.
    always_comb begin
        hsync_nxt  = ((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST)) ? H_SYNC_POL : HS_IDLE;
        vsync_nxt  = ((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST)) ? V_SYNC_POL : VS_IDLE;
        active_nxt = (col_nxt < COL_ACT) && (row_nxt < ROW_ACT);
    end

    // Output registers; disable behaves exactly like reset but takes effect on the clock.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_Rst_n) begin
            o_Col         <= '0;
            o_Row         <= '0;
            o_Hsync       <= HS_IDLE;
            o_Vsync       <= VS_IDLE;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else if (!i_Enable) begin
            o_Col         <= '0;
            o_Row         <= '0;
            o_Hsync       <= HS_IDLE;
            o_Vsync       <= VS_IDLE;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Col         <= col_nxt;
            o_Row         <= row_nxt;
            o_Hsync       <= hsync_nxt;
            o_Vsync       <= vsync_nxt;
            o_Active      <= active_nxt;
            o_Line_Start  <= col_wrap;
            o_Frame_Start <= col_wrap && row_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives three vga_timing_gen instances with shared stimulus
// (full 640x480 mode, default horizontal timing with a short frame and inverted
// sync polarity, and a tiny 8x6 mode) and compares each against a model that
// tracks only the number of pixel advances since the last reset/disable.
module tb_vga_timing_gen;

    typedef struct {
        int ac, hfp, hsw, hbp;
        int ar, vfp, vsw, vbp;
        bit hp, vp;
    } mode_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic pix_en;

    logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;
    logic a_hs, a_vs, a_act, a_ls, a_fs;
    logic b_hs, b_vs, b_act, b_ls, b_fs;
    logic c_hs, c_vs, c_act, c_ls, c_fs;

    // Full default mode.
    vga_timing_gen dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Pix_En(pix_en),
        .o_Col(a_col), .o_Row(a_row), .o_Hsync(a_hs), .o_Vsync(a_vs),
        .o_Active(a_act), .o_Line_Start(a_ls), .o_Frame_Start(a_fs)
    );

    // Default horizontal timing, short frame, active-high syncs.
    vga_timing_gen #(
        .ACTIVE_ROWS(8), .V_FRONT_PORCH(2), .V_SYNC_WIDTH(2), .V_BACK_PORCH(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Pix_En(pix_en),
        .o_Col(b_col), .o_Row(b_row), .o_Hsync(b_hs), .o_Vsync(b_vs),
        .o_Active(b_act), .o_Line_Start(b_ls), .o_Frame_Start(b_fs)
    );

    // Tiny mode: 8 columns by 6 rows.
    vga_timing_gen #(
        .ACTIVE_COLS(4), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1),
        .ACTIVE_ROWS(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1)
    ) dut_c (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Pix_En(pix_en),
        .o_Col(c_col), .o_Row(c_row), .o_Hsync(c_hs), .o_Vsync(c_vs),
        .o_Active(c_act), .o_Line_Start(c_ls), .o_Frame_Start(c_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: advances since (0,0), idle flag, strobe values.
    mode_t modes[3];
    longint adv[3];
    bit     idle[3];
    bit     ls_m[3];
    bit     fs_m[3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic int tcols(int m);
        return modes[m].ac + modes[m].hfp + modes[m].hsw + modes[m].hbp;
    endfunction

    function automatic int trows(int m);
        return modes[m].ar + modes[m].vfp + modes[m].vsw + modes[m].vbp;
    endfunction

    function automatic int m_col(int m);
        return int'(adv[m] % tcols(m));
    endfunction

    function automatic int m_row(int m);
        return int'((adv[m] / tcols(m)) % trows(m));
    endfunction

    function automatic logic [24:0] exp_vec(int m);
        int  col, row;
        logic hs, vs, act;
        col = m_col(m);
        row = m_row(m);
        if (idle[m]) begin
            hs  = ~modes[m].hp;
            vs  = ~modes[m].vp;
            act = 1'b0;
        end else begin
            hs  = (col >= modes[m].ac + modes[m].hfp &&
                   col <  modes[m].ac + modes[m].hfp + modes[m].hsw) ? modes[m].hp : ~modes[m].hp;
            vs  = (row >= modes[m].ar + modes[m].vfp &&
                   row <  modes[m].ar + modes[m].vfp + modes[m].vsw) ? modes[m].vp : ~modes[m].vp;
            act = (col < modes[m].ac) && (row < modes[m].ar);
        end
        return {10'(col), 10'(row), hs, vs, act, ls_m[m], fs_m[m]};
    endfunction

    function automatic logic [24:0] obs_vec(int m);
        case (m)
            0:       return {a_col, a_row, a_hs, a_vs, a_act, a_ls, a_fs};
            1:       return {b_col, b_row, b_hs, b_vs, b_act, b_ls, b_fs};
            default: return {c_col, c_row, c_hs, c_vs, c_act, c_ls, c_fs};
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            adv[m]  = 0;
            idle[m] = 1'b1;
            ls_m[m] = 1'b0;
            fs_m[m] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic en, input logic pe);
        if (!rst_n) return;
        if (!en) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 3; m++) begin
            idle[m] = 1'b0;
            if (pe) begin
                adv[m]  = (adv[m] + 1) % (tcols(m) * trows(m));
                ls_m[m] = (adv[m] % tcols(m)) == 0;
                fs_m[m] = adv[m] == 0;
            end else begin
                ls_m[m] = 1'b0;
                fs_m[m] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 3; m++) begin
            logic [24:0] o, e;
            o = obs_vec(m);
            e = exp_vec(m);
            checks++;
            assert (o === e) else begin
                errors++;
                if (errors <= 20)
                    $error("FAIL %s mode%0d: observed col=%0d row=%0d hs/vs/act/ls/fs=%b, expected col=%0d row=%0d hs/vs/act/ls/fs=%b",
                           tag, m, o[24:15], o[14:5], o[4:0], e[24:15], e[14:5], e[4:0]);
            end
        end
    endtask

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, sample #1 later.
    task automatic step(input logic en, input logic pe, input string tag);
        enable = en;
        pix_en = pe;
        @(posedge clk);
        model_edge(en, pe);
        cyc++;
        #1;
        check_all(tag);
    endtask

    initial begin
        int act_cnt;
        int last_fs;
        bit period_done;
        int guard;

        modes[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        modes[1] = '{640, 16, 96, 48,   8,  2, 2,  2, 1'b1, 1'b1};
        modes[2] = '{  4,  1,  2,  1,   3,  1, 1,  1, 1'b0, 1'b0};

        // Reset held across clock edges.
        rst_n  = 1'b0;
        enable = 1'b1;
        pix_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Release with a held pixel strobe: first edge only raises active.
        rst_n = 1'b1;
        step(1'b1, 1'b0, "release_hold");
        step(1'b1, 1'b0, "release_hold2");

        // Continuous advance through several default-mode lines.
        for (int i = 0; i < 2500; i++) step(1'b1, 1'b1, "cont_lines");

        // One full short frame on dut_b, counting active pixels.
        act_cnt = 0;
        for (int i = 0; i < 11200; i++) begin
            step(1'b1, 1'b1, "cont_frame");
            act_cnt += int'(b_act);
        end
        check_val("active_count_b", act_cnt, 640 * 8);

        // Pixel strobe every 4th clock; measure tiny-mode frame period.
        last_fs     = -1;
        period_done = 1'b0;
        for (int i = 0; i < 3600; i++) begin
            step(1'b1, (i % 4) == 3, "every4");
            if (c_fs && !period_done) begin
                if (last_fs >= 0) begin
                    check_val("frame_period_c", cyc - last_fs, 4 * 48);
                    period_done = 1'b1;
                end
                last_fs = cyc;
            end
        end
        check_val("period_measured", period_done, 1);

        // Randomised strobe with rare enable drops.
        for (int i = 0; i < 15000; i++)
            step($urandom_range(0, 999) != 0, $urandom_range(0, 2) != 0, "random");

        // Seek dut_b to col 700, row 11 (inside both syncs), then reset between edges.
        guard = 0;
        while (!(m_col(1) == 700 && m_row(1) == 11 && !idle[1]) && guard < 12000) begin
            step(1'b1, 1'b1, "seek_sync");
            guard++;
        end
        check_val("seek_sync_found", guard < 12000, 1);
        check_val("b_hsync_in_pulse", b_hs, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        step(1'b1, 1'b1, "reset_held");
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1, "after_reset");

        // Drop enable at col 300 of the default mode, then re-enable.
        guard = 0;
        while (m_col(0) != 300 && guard < 1000) begin
            step(1'b1, 1'b1, "seek_col300");
            guard++;
        end
        check_val("seek_col300_found", guard < 1000, 1);
        step(1'b0, 1'b1, "disable");
        step(1'b0, 1'b1, "disable_hold");
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, "reenable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
